folded_maj_engine: RTL
======================

FOLDED_MAJ_ENGINE -- requirements
Module: folded_maj_engine

Interface
REQ-001 Parameter N_IN, default 45: number of voting inputs; legal range 3..256.
REQ-002 Parameter CHUNK, default 9: bits popcounted per cycle; legal range 1..N_IN.
REQ-003 Derived constants:
  - NCHUNK = ceil(N_IN/CHUNK)
  - CW = clog2(N_IN+1)
  - MAJ_THR = N_IN/2 + 1 (integer division; 23 for N_IN=45)
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-006 in_valid  input  1  x, thr_in and maj_mode are valid.
REQ-007 in_ready  output  1  block can accept a vector.
REQ-008 x  input  N_IN  voting vector; bit i is voter i.
REQ-009 maj_mode  input  1  1 = majority threshold MAJ_THR; 0 = use thr_in.
REQ-010 thr_in  input  CW+1  programmable threshold, used only when maj_mode=0.
REQ-011 out_valid  output  1  result is valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 y  output  1  decision: 1 iff count >= effective threshold.
REQ-014 count  output  CW  popcount of the captured x.

Function
REQ-015 FSM states: IDLE, ACCUM, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 IDLE, on edge with in_valid=1: capture x, capture effective threshold (MAJ_THR or thr_in), clear accumulator and chunk index, go to ACCUM.
REQ-017 ACCUM, each edge: add popcount of chunk[idx] (bits idx*CHUNK .. idx*CHUNK+CHUNK-1) to the accumulator, then increment idx.
REQ-018 Last chunk is zero-padded above bit N_IN-1; padding never contributes to count.
REQ-019 ACCUM exit: on the edge that processes idx=NCHUNK-1, load count and y and go to DONE.
REQ-020 Latency: out_valid rises exactly NCHUNK cycles after the accepting edge (5 cycles at defaults).
REQ-021 Accumulator is CW bits wide and cannot overflow.
REQ-022 Comparison is unsigned, performed at CW+1 bits.
REQ-023 Threshold boundaries:
  - threshold 0: y=1.
  - threshold > N_IN: y=0.
REQ-024 DONE: y, count and out_valid are held stable while out_ready=0.
REQ-025 DONE, on edge with out_ready=1: go to IDLE.
REQ-026 No new vector is accepted in the DONE-to-IDLE edge; maximum throughput is one vector per NCHUNK+2 cycles.
REQ-027 Inputs x, thr_in and maj_mode are ignored outside the accepting edge; changes during ACCUM do not affect the result.
REQ-028 Degenerate case CHUNK=N_IN: NCHUNK=1, latency 1 cycle.

Reset
REQ-029 rst_n=0 at an edge forces IDLE, accumulator=0, idx=0, count=0, y=0, out_valid=0; in_ready=1 from the first edge after release.
REQ-030 Reset asserted during ACCUM or DONE aborts the operation; no out_valid is produced for the aborted vector.
REQ-031 No output depends combinationally on rst_n.

Structure
REQ-032 Package folded_maj_pkg holds:
  - FSM state enum
  - functions computing NCHUNK, CW and MAJ_THR from parameters
REQ-033 Sub-module popcount_chunk (parameter CHUNK): combinational popcount of a CHUNK-bit slice, output clog2(CHUNK+1) bits; instantiated once.
REQ-034 Chunk selection uses an indexed part-select of the captured, zero-extended vector (width NCHUNK*CHUNK).

Verification
REQ-035 Defaults, x=0, maj_mode=1 -> out_valid 5 cycles after accept, count=0, y=0.
REQ-036 Defaults, x with 23 ones -> count=23, y=1; x with 22 ones -> count=22, y=0.
REQ-037 maj_mode=0, x all ones (45 ones):
  - thr_in=45 -> y=1.
  - thr_in=46 -> y=0.
  - thr_in=0 with x=0 -> y=1.
REQ-038 out_ready held 0 for 10 cycles in DONE -> y, count and out_valid stable, in_ready=0 throughout; one cycle of out_ready=1 -> IDLE on the next edge.
REQ-039 rst_n=0 for one edge during ACCUM cycle 3 -> IDLE, out_valid never rises; next vector (x with 30 ones) -> count=30, y=1.
REQ-040 Random regression at N_IN=45/CHUNK=9, N_IN=8/CHUNK=3 and N_IN=7/CHUNK=7, with randomized in_valid/out_ready -> y and count match the popcount reference for every vector.

Source files
------------

// File: rtl/folded_maj_pkg.sv
// Shared types and parameter-derived sizing for the folded majority engine.
// Keeping the derivations here lets the top and any bench agree on widths.
package folded_maj_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Number of CHUNK-bit slices needed to cover n_in voters.
  function automatic int calc_nchunk(input int n_in, input int chunk);
    return (n_in + chunk - 1) / chunk;
  endfunction

  // Width able to hold any popcount from 0 to n_in inclusive.
  function automatic int calc_cw(input int n_in);
    return $clog2(n_in + 1);
  endfunction

  function automatic int calc_maj_thr(input int n_in);
    return n_in / 2 + 1;
  endfunction

endpackage

// File: rtl/folded_maj_engine_popcount_chunk.sv
// Combinational popcount of one CHUNK-bit slice of the voting vector.
module popcount_chunk #(
  parameter  int CHUNK = 9,
  localparam int SW    = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] bits,
  output logic [SW-1:0]    ones
);

  // NOTE: blocking assignments are correct here; the loop builds a running sum
  // inside one combinational evaluation, so each step must see the previous one.
  always_comb begin
    ones = '0;
    for (int i = 0; i < CHUNK; i++) begin
      ones = ones + SW'(bits[i]);
    end
  end

endmodule

// File: rtl/folded_maj_engine.sv
// Folded threshold/majority voter: popcounts a captured vector CHUNK bits per
// cycle, then compares the total with a majority or programmable threshold.
module folded_maj_engine
  import folded_maj_pkg::*;
#(
  parameter  int N_IN  = 45,
  parameter  int CHUNK = 9,
  localparam int CW    = calc_cw(N_IN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] x,
  input  logic            maj_mode,
  input  logic [CW:0]     thr_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            y,
  output logic [CW-1:0]   count
);

  localparam int NCHUNK  = calc_nchunk(N_IN, CHUNK);
  localparam int MAJ_THR = calc_maj_thr(N_IN);
  localparam int PW      = NCHUNK * CHUNK;
  localparam int IW      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int SW      = $clog2(CHUNK + 1);

  localparam logic [IW-1:0] LAST_IDX  = IW'(NCHUNK - 1);
  localparam logic [CW:0]   MAJ_THR_W = (CW + 1)'(MAJ_THR);

  state_t state_q, state_d;

  logic [PW-1:0]    vec_q;
  logic [CW:0]      thr_q;
  logic [CW-1:0]    acc_q;
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    count_q;
  logic             y_q;

  logic             accept;
  logic             last_chunk;
  logic [CHUNK-1:0] chunk_bits;
  logic [SW-1:0]    chunk_ones;
  logic [CW-1:0]    acc_sum;
  logic             decision;

  assign accept     = (state_q == IDLE) && in_valid;
  assign last_chunk = (idx_q == LAST_IDX);

  // Padding bits above N_IN-1 are zero in vec_q, so they never add to the sum.
  assign chunk_bits = vec_q[int'(idx_q) * CHUNK +: CHUNK];

  popcount_chunk #(
    .CHUNK(CHUNK)
  ) u_popcount_chunk (
    .bits(chunk_bits),
    .ones(chunk_ones)
  );

  // The running total never exceeds N_IN, so CW bits cannot wrap.
  assign acc_sum  = acc_q + CW'(chunk_ones);
  assign decision = ({1'b0, acc_sum} >= thr_q);

  // NOTE: every variable gets its default before the case so no path can
  // leave state_d unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)   state_d = ACCUM;
      ACCUM:   if (last_chunk) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        acc_q <= '0;
        idx_q <= '0;
      end else if (state_q == ACCUM) begin
        acc_q <= acc_sum;
        if (last_chunk) begin
          count_q <= acc_sum;
          y_q     <= decision;
        end else begin
          idx_q <= idx_q + IW'(1);
        end
      end
    end
  end

  // NOTE: the captured vector and threshold have no reset; they are only read
  // in ACCUM, which is reachable solely through an accepting edge that loads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      vec_q <= PW'(x);
      thr_q <= maj_mode ? MAJ_THR_W : thr_in;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign count     = count_q;
  assign y         = y_q;

endmodule
